// File: rtl/uart_rpt_pkg.sv
// Shared types and constants for the counter-value UART reporter.
package uart_rpt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    LOAD,
    SEND,
    WAIT,
    DONE
  } rpt_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned sat_limit(input int unsigned digits);
    longint unsigned lim;
    lim = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      lim = lim * 10;
    end
    return lim - 1;
  endfunction

endpackage

// File: rtl/uart_cnt_reporter_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one shift per cycle, CNT_W shifts per conversion.
module bin2bcd_seq #(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        bin_i,
  output logic                    done_o,
  output logic [NUM_DIGITS*4-1:0] bcd_o
);

  localparam int unsigned BCD_W = NUM_DIGITS * 4;
  localparam int unsigned CW    = $clog2(CNT_W + 1);

  logic [CNT_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[CNT_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(CNT_W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_cnt_reporter.sv
// Sends a latched counter value to the UART as ASCII decimal (+ optional CR LF), one byte per tx handshake.
// Optional: define UART_RPT_ZERO_SUPPRESS_EN to skip leading zero digits (units digit always sent).
module uart_cnt_reporter
  import uart_rpt_pkg::*;
#(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEND_CRLF  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_tx_done,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned     FRAME_LEN = NUM_DIGITS + ((SEND_CRLF != 0) ? 2 : 0);
  localparam int unsigned     IDX_W     = $clog2(FRAME_LEN + 1);
  localparam longint unsigned LIMIT     = sat_limit(NUM_DIGITS);

  rpt_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              data_q, data_d;
  logic [7:0]              byte_sel;
  logic [IDX_W-1:0]        first_idx;
  logic [CNT_W-1:0]        cnt_sat;
  logic                    conv_start;
  logic                    conv_done;
  logic [NUM_DIGITS*4-1:0] bcd;

  assign cnt_sat = (64'(i_count) > LIMIT) ? CNT_W'(LIMIT) : i_count;

  bin2bcd_seq #(
    .CNT_W      (CNT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (cnt_sat),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Byte index 0 is the most significant digit; CR and LF follow the digits.
  always_comb begin
    byte_sel = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        byte_sel = ASCII_ZERO + {4'h0, bcd[(NUM_DIGITS-1-i)*4 +: 4]};
      end
    end
    if (idx_q == IDX_W'(NUM_DIGITS)) begin
      byte_sel = ASCII_CR;
    end
    if (idx_q == IDX_W'(NUM_DIGITS + 1)) begin
      byte_sel = ASCII_LF;
    end
  end

`ifdef UART_RPT_ZERO_SUPPRESS_EN
  logic seen_nz;
  always_comb begin
    first_idx = IDX_W'(NUM_DIGITS - 1);
    seen_nz   = 1'b0;
    for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
      if (!seen_nz && (bcd[(NUM_DIGITS-1-i)*4 +: 4] != 4'd0)) begin
        first_idx = IDX_W'(i);
        seen_nz   = 1'b1;
      end
    end
  end
`else
  assign first_idx = '0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    conv_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_trig) begin
          conv_start = 1'b1;
          idx_d      = '0;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          idx_d   = first_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = byte_sel;
        state_d = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign o_tx_start = (state_q == SEND);
  assign o_tx_data  = data_q;
  assign o_busy     = (state_q != IDLE) && (state_q != DONE);
  assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_uart_cnt_reporter.sv
// Directed bench for uart_cnt_reporter with a decimal-formatting reference model and a per-cycle monitor.
module tb_uart_cnt_reporter;

  localparam int unsigned CNT_W      = 14;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned TX_DELAY   = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_trig = 1'b0;
  logic [CNT_W-1:0] i_count = '0;
  logic             i_tx_done = 1'b0;
  logic             o_tx_start;
  logic [7:0]       o_tx_data;
  logic             o_busy;
  logic             o_done;

  uart_cnt_reporter #(
    .CNT_W      (CNT_W),
    .NUM_DIGITS (NUM_DIGITS),
    .SEND_CRLF  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_trig     (i_trig),
    .i_count    (i_count),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  expq[$];
  int unsigned exp_len = 0;
  int unsigned starts_in_frame = 0;
  bit          first_pending = 1'b0;
  int unsigned acc_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned stray_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: saturate, format as decimal text, append CR LF.
  function automatic int unsigned sat(input int unsigned v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int unsigned ndig(input int unsigned s);
`ifdef UART_RPT_ZERO_SUPPRESS_EN
    int unsigned n = 1;
    int unsigned t = s;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
`else
    return NUM_DIGITS;
`endif
  endfunction

  function automatic int unsigned model_len(input int unsigned v);
    return ndig(sat(v)) + 2;
  endfunction

  function automatic logic [7:0] model_byte(input int unsigned v, input int unsigned i);
    int unsigned s = sat(v);
    int unsigned n = ndig(s);
    int unsigned p = 1;
    if (i < n) begin
      for (int unsigned k = 0; k + 1 + i < n; k++) p = p * 10;
      return 8'h30 + 8'((s / p) % 10);
    end
    return (i == n) ? 8'h0D : 8'h0A;
  endfunction

  // Monitor + UART responder: the only driver of i_tx_done.
  initial begin
    int unsigned cd = 0;
    int unsigned stray_seen = 0;
    bit          in_wait = 1'b0;
    logic [7:0]  hold_byte = '0;
    logic [7:0]  e;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (!reset) begin
        cd      = 0;
        in_wait = 1'b0;
      end else begin
        if (in_wait) chk("tx_data_hold", o_tx_data, hold_byte);
        if (o_tx_start) begin
          chk("start_busy", o_busy, 1);
          chk("start_expected", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("tx_byte", o_tx_data, e);
          end
          if (first_pending) chk("first_latency", cyc - acc_cyc, CNT_W + 2);
          else               chk("start_gap", cyc - done_cyc, 2);
          first_pending = 1'b0;
          starts_in_frame++;
          hold_byte = o_tx_data;
          in_wait   = 1'b1;
          cd        = TX_DELAY;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            i_tx_done = 1'b1;
            done_cyc  = cyc;
            in_wait   = 1'b0;
          end
        end
        if (o_done) begin
          chk("done_busy", o_busy, 0);
          chk("done_all_sent", expq.size(), 0);
        end
        if (stray_cnt != stray_seen) begin
          stray_seen = stray_cnt;
          i_tx_done  = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input int unsigned v, input bit accept);
    tick();
    i_count = CNT_W'(v);
    i_trig  = 1'b1;
    if (accept) begin
      exp_len = model_len(v);
      for (int unsigned i = 0; i < exp_len; i++) expq.push_back(model_byte(v, i));
      starts_in_frame = 0;
      first_pending   = 1'b1;
    end
    tick();
    if (accept) begin
      acc_cyc = cyc;
      chk("busy_after_trig", o_busy, 1);
    end
    i_trig  = 1'b0;
    i_count = CNT_W'(16383);
  endtask

  task automatic wait_frame(input bit poke_in_done);
    int unsigned k = 0;
    while (!o_done && k < 400) begin
      tick();
      k++;
    end
    chk("frame_done", o_done, 1);
    chk("frame_len", starts_in_frame, exp_len);
    chk("frame_drained", expq.size(), 0);
    if (poke_in_done) begin
      i_count = CNT_W'(5555);
      i_trig  = 1'b1;
    end
    tick();
    i_trig = 1'b0;
    chk("done_single", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  task automatic wait_starts(input int unsigned n);
    int unsigned k = 0;
    while (starts_in_frame < n && k < 400) begin
      tick();
      k++;
    end
    chk("reach_start", starts_in_frame >= n, 1);
  endtask

  initial begin
    logic [7:0] lit [6];
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};

    repeat (3) tick();
    chk("rst_start", o_tx_start, 0);
    chk("rst_data", o_tx_data, 8'h00);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) chk("model_1234", model_byte(1234, i), lit[i]);
    chk("model_sat", model_byte(12000, 0), 8'h39);
`ifdef UART_RPT_ZERO_SUPPRESS_EN
    chk("model_len_7", model_len(7), 3);
    chk("model_7", model_byte(7, 0), 8'h37);
`else
    chk("model_len_7", model_len(7), 6);
    chk("model_7", model_byte(7, 3), 8'h37);
`endif

    trig(1234, 1);  wait_frame(1'b0);
    trig(0, 1);     wait_frame(1'b0);
    trig(7, 1);     wait_frame(1'b0);
    trig(12000, 1); wait_frame(1'b0);

    // Triggers while busy and in the DONE cycle are dropped.
    trig(1234, 1);
    wait_starts(3);
    trig(5555, 0);
    wait_frame(1'b1);
    repeat (5) tick();
    chk("no_queued_trig", o_busy, 0);
    trig(42, 1);    wait_frame(1'b0);

    // Reset in WAIT of byte 2 aborts the frame.
    trig(1234, 1);
    wait_starts(2);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("abort_start", o_tx_start, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_data", o_tx_data, 8'h00);
    reset = 1'b1;
    expq.delete();
    first_pending = 1'b0;
    repeat (30) tick();
    chk("abort_no_starts", starts_in_frame, 2);
    trig(9876, 1);  wait_frame(1'b0);

    // Stray i_tx_done in IDLE and during conversion.
    stray_cnt++;
    repeat (3) tick();
    chk("stray_idle_busy", o_busy, 0);
    trig(321, 1);
    repeat (4) tick();
    stray_cnt++;
    wait_frame(1'b0);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
